// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {RUN, STALL, FLUSH} hz_state_t;
  typedef logic [4:0] regaddr_t;
  localparam regaddr_t REG_X0 = 5'd0;
  function automatic int cnt_width(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode/EX hazard inputs and pipeline control outputs
interface hazard_ctrl_if #(parameter int CNT_W = 32) ();
  import hazard_pkg::*;
  regaddr_t id_rs1;
  regaddr_t id_rs2;
  logic id_rs1_used;
  logic id_rs2_used;
  regaddr_t ex_rd;
  logic ex_memtoreg;
  logic ex_regwrite;
  logic ex_branch_taken;
  logic pc_write_en;
  logic ifid_write_en;
  logic ifid_flush;
  logic idex_flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_cycles;
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memtoreg, ex_regwrite, ex_branch_taken,
    input pc_write_en, ifid_write_en, ifid_flush, idex_flush, stall_cycles, flush_cycles
  );
  modport slave (
    input id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_memtoreg, ex_regwrite, ex_branch_taken,
    output pc_write_en, ifid_write_en, ifid_flush, idex_flush, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: counter that clears on reset and holds at all-ones
module sat_counter #(parameter int W = 32) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q;
  // count up on inc until all-ones, then hold
  always_ff @(posedge clk)
    count_q <= reset ? '0 : (inc && count_q != '1) ? count_q + W'(1) : count_q;
  assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and taken-branch flush sequencing for IF/ID and ID/EX
module hazard_ctrl import hazard_pkg::*; #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 32
) (
  input logic clk,
  input logic reset,
  hazard_ctrl_if.slave hz
);
  localparam int CW = cnt_width(LOAD_STALL_CYCLES, FLUSH_CYCLES);
  hz_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic load_use, run_br, run_lu, stall_now;
  assign load_use = hz.ex_memtoreg && hz.ex_regwrite && hz.ex_rd != REG_X0 &&
                    ((hz.id_rs1_used && hz.id_rs1 == hz.ex_rd) || (hz.id_rs2_used && hz.id_rs2 == hz.ex_rd));
  // a taken branch outranks load-use: the consumer is on the wrong path
  assign run_br    = state_q == RUN && hz.ex_branch_taken;
  assign run_lu    = state_q == RUN && !hz.ex_branch_taken && load_use;
  assign stall_now = run_lu || state_q == STALL;
  assign hz.pc_write_en   = !reset && !stall_now;
  assign hz.ifid_write_en = !reset && !stall_now;
  assign hz.ifid_flush    = reset || run_br || state_q == FLUSH;
  assign hz.idex_flush    = reset || run_br || stall_now;
  // next state: enter a multi-cycle sequence or count the current one down
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (run_br && FLUSH_CYCLES > 1) begin
      state_d = FLUSH;
      cnt_d   = CW'(FLUSH_CYCLES - 1);
    end else if (run_lu && LOAD_STALL_CYCLES > 1) begin
      state_d = STALL;
      cnt_d   = CW'(LOAD_STALL_CYCLES - 1);
    end else if (state_q != RUN) begin
      cnt_d   = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? RUN : state_q;
    end
  end
  // state register; reset drops any remaining stall/flush count
  always_ff @(posedge clk) begin
    state_q <= reset ? RUN : state_d;
    cnt_q   <= reset ? '0 : cnt_d;
  end
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk(clk), .reset(reset), .inc(!hz.pc_write_en), .count(hz.stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk(clk), .reset(reset), .inc(hz.ifid_flush), .count(hz.flush_cycles)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two configurations checked against a schedule-queue reference model
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic rs1_used = 1'b0, rs2_used = 1'b0, memtoreg = 1'b0, regwrite = 1'b0, br = 1'b0;
  int checks = 0;
  int failures = 0;
  int ls [2] = '{1, 3};
  int fc [2] = '{1, 3};
  longint cmax [2] = '{64'hFFFF_FFFF, 64'd15};
  longint sc [2] = '{0, 0};
  longint fl [2] = '{0, 0};
  logic [3:0] sched [2][$];
  always #5 clk = ~clk;
  hazard_ctrl_if #(.CNT_W(32)) ifa ();
  hazard_ctrl_if #(.CNT_W(4))  ifb ();
  assign ifa.id_rs1 = rs1;           assign ifb.id_rs1 = rs1;
  assign ifa.id_rs2 = rs2;           assign ifb.id_rs2 = rs2;
  assign ifa.id_rs1_used = rs1_used; assign ifb.id_rs1_used = rs1_used;
  assign ifa.id_rs2_used = rs2_used; assign ifb.id_rs2_used = rs2_used;
  assign ifa.ex_rd = rd;             assign ifb.ex_rd = rd;
  assign ifa.ex_memtoreg = memtoreg; assign ifb.ex_memtoreg = memtoreg;
  assign ifa.ex_regwrite = regwrite; assign ifb.ex_regwrite = regwrite;
  assign ifa.ex_branch_taken = br;   assign ifb.ex_branch_taken = br;
  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (.clk(clk), .reset(reset), .hz(ifa.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(4))  dut_b (.clk(clk), .reset(reset), .hz(ifb.slave));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one cycle: outputs {pc_we, ifid_we, ifid_flush, idex_flush} come from the
  // pending schedule if one exists, otherwise from the RUN-cycle rules
  task automatic tick(input string tag);
    logic lu;
    logic [3:0] e [2];
    logic [3:0] got [2];
    logic [63:0] gs [2], gf [2];
    @(negedge clk);
    lu = memtoreg && regwrite && rd != 0 && ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
    got[0] = {ifa.pc_write_en, ifa.ifid_write_en, ifa.ifid_flush, ifa.idex_flush};
    got[1] = {ifb.pc_write_en, ifb.ifid_write_en, ifb.ifid_flush, ifb.idex_flush};
    gs[0] = 64'(ifa.stall_cycles); gf[0] = 64'(ifa.flush_cycles);
    gs[1] = 64'(ifb.stall_cycles); gf[1] = 64'(ifb.flush_cycles);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        e[k] = 4'b0011;
        sched[k].delete();
      end else if (sched[k].size() > 0) e[k] = sched[k].pop_front();
      else if (br) begin
        e[k] = 4'b1111;
        repeat (fc[k] - 1) sched[k].push_back(4'b1110);
      end else if (lu) begin
        e[k] = 4'b0001;
        repeat (ls[k] - 1) sched[k].push_back(4'b0001);
      end else e[k] = 4'b1100;
      chk($sformatf("%s/%0d/ctl", tag, k), 64'(got[k]), 64'(e[k]));
      chk($sformatf("%s/%0d/stall_cnt", tag, k), gs[k], sc[k]);
      chk($sformatf("%s/%0d/flush_cnt", tag, k), gf[k], fl[k]);
      if (reset) begin
        sc[k] = 0;
        fl[k] = 0;
      end else begin
        if (!e[k][3] && sc[k] < cmax[k]) sc[k]++;
        if (e[k][1] && fl[k] < cmax[k]) fl[k]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                        input logic [4:0] d, input logic m, input logic w, input logic b);
    rs1 = r1; rs1_used = u1; rs2 = r2; rs2_used = u2; rd = d; memtoreg = m; regwrite = w; br = b;
  endtask

  initial begin
    tick("reset0");
    tick("reset1");
    reset = 1'b0;
    set_in(5, 1, 0, 0, 5, 1, 1, 0); tick("lu");
    set_in(5, 1, 0, 0, 5, 0, 1, 0); tick("lu_next");
    chk("lu_stall_cnt_a", 64'(ifa.stall_cycles), 64'd1);
    tick("lu_drain0");
    set_in(0, 1, 0, 0, 0, 1, 1, 0); tick("x0");
    set_in(0, 0, 7, 0, 7, 1, 1, 0); tick("rs2_unused");
    reset = 1'b1; tick("rst_br");
    reset = 1'b0;
    set_in(5, 1, 0, 0, 5, 1, 1, 1); tick("br_lu");
    chk("br_flush_cnt_a", 64'(ifa.flush_cycles), 64'd1);
    chk("br_stall_cnt_a", 64'(ifa.stall_cycles), 64'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 1); tick("flush_c2_br");
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick("flush_c3");
    tick("after_flush");
    set_in(9, 1, 0, 0, 9, 1, 1, 0); tick("lu_b");
    reset = 1'b1; tick("rst_in_stall");
    chk("rst_stall_cnt_b", 64'(ifb.stall_cycles), 64'd0);
    reset = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0); tick("post_rst");
    reset = 1'b1; tick("rst_sat");
    reset = 1'b0;
    set_in(3, 0, 3, 1, 3, 1, 1, 0);
    repeat (20) tick("sat");
    chk("sat_stall_cnt_b", 64'(ifb.stall_cycles), 64'd15);
    for (int i = 0; i < 400; i++) begin
      reset = $urandom_range(0, 39) == 0;
      set_in(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
             5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
      tick("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
